acc_tc_sat: RTL and testbench

- Accumulates a stream of signed 32-bit two's-complement values, such as the sums produced by the two's-complement adder stage, over a programmed number of terms.
- Emits one saturated, narrowed result per run through a valid/ready handshake.
- Sits directly downstream of the adder and feeds the requantised result to the next datapath stage.

---
 rtl/acc_tc_sat.sv | 130 +++++++++++++
 tb/tb_acc_tc_sat.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_tc_sat.sv
// Signed stream accumulator: sums a programmed number of 32-bit two's-complement
// terms and hands out one saturated OW-bit result per run over valid/ready.
module acc_tc_sat #(
  parameter int OW = 16,
  parameter int LW = 16,
  parameter int AW = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_sat,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Output clip limits expressed at accumulator width so the compares are exact.
  localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  state_t               state_r;
  logic signed [AW-1:0] acc_r;
  logic [LW-1:0]        cnt_r;
  logic [LW-1:0]        len_r;
  logic signed [AW-1:0] sum_s;
  logic [LW-1:0]        cnt_inc_s;
  logic                 beat_s;
  logic                 last_s;

  // Returns {clipped_flag, narrowed_value} for an accumulator-width sum.
  function automatic logic [OW:0] sat_fn(input logic signed [AW-1:0] s);
    logic [OW:0] r;
    if (s > MAXV) begin
      r = {1'b1, MAXV[OW-1:0]};
    end else if (s < MINV) begin
      r = {1'b1, MINV[OW-1:0]};
    end else begin
      r = {1'b0, s[OW-1:0]};
    end
    return r;
  endfunction

  // Next accumulator value and beat/last-beat qualifiers.
  always_comb begin
    sum_s     = acc_r + {{(AW-32){in_data[31]}}, in_data};
    cnt_inc_s = cnt_r + {{(LW-1){1'b0}}, 1'b1};
    beat_s    = in_valid & in_ready;
    last_s    = (cnt_inc_s == len_r);
  end

  // Control FSM, accumulator and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      acc_r     <= {AW{1'b0}};
      cnt_r     <= {LW{1'b0}};
      len_r     <= {LW{1'b0}};
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {OW{1'b0}};
      out_sat   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != {LW{1'b0}}) begin
              len_r    <= len;
              acc_r    <= {AW{1'b0}};
              cnt_r    <= {LW{1'b0}};
              in_ready <= 1'b1;
              state_r  <= ACCUM;
            end else begin
              out_data  <= {OW{1'b0}};
              out_sat   <= 1'b0;
              out_valid <= 1'b1;
              state_r   <= HOLD;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ACCUM: begin
          if (beat_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_inc_s;
            if (last_s) begin
              {out_sat, out_data} <= sat_fn(sum_s);
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state_r   <= HOLD;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_tc_sat.sv
// Bench for acc_tc_sat: OW=16 and OW=32 instances share one stimulus stream and
// are checked each cycle against a transaction-level model plus literal results.
module tb_acc_tc_sat;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, out_ready;
  logic [15:0] len;
  logic [31:0] in_data;
  logic        ir16, ov16, os16, bz16, ir32, ov32, os32, bz32;
  logic [15:0] od16;
  logic [31:0] od32;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int vq[$];
  bit vpat[$];

  always #5 clk = ~clk;

  acc_tc_sat #(.OW(16), .LW(16), .AW(48)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(ir16), .in_data(in_data), .out_valid(ov16), .out_ready(out_ready),
    .out_data(od16), .out_sat(os16), .busy(bz16));

  acc_tc_sat #(.OW(32), .LW(16), .AW(48)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(ir32), .in_data(in_data), .out_valid(ov32), .out_ready(out_ready),
    .out_data(od32), .out_sat(os32), .busy(bz32));

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint satv(input longint s, input int ow);
    longint mx;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    if (s > mx) return mx;
    else if (s < -mx - 1) return -mx - 1;
    else return s;
  endfunction

  // Reference model: a run is "waiting", "collecting terms" or "offering a result".
  int     m_mode = 0;
  int     m_left = 0;
  longint m_sum = 0;
  longint m_d16 = 0, m_d32 = 0;
  bit     m_s16 = 1'b0, m_s32 = 1'b0;
  longint fin;

  always @(posedge clk) begin
    fin = m_sum + longint'($signed(in_data));
    if (!rst_n) begin
      m_mode <= 0; m_left <= 0; m_sum <= 0;
      m_d16 <= 0; m_d32 <= 0; m_s16 <= 1'b0; m_s32 <= 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin
          if (len != 16'd0) begin
            m_mode <= 1; m_left <= int'(len); m_sum <= 0;
          end else begin
            m_mode <= 2; m_d16 <= 0; m_d32 <= 0; m_s16 <= 1'b0; m_s32 <= 1'b0;
          end
        end
        1: if (in_valid) begin
          m_sum  <= fin;
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_mode <= 2;
            m_d16 <= satv(fin, 16); m_s16 <= (satv(fin, 16) != fin);
            m_d32 <= satv(fin, 32); m_s32 <= (satv(fin, 32) != fin);
          end
        end
        2: if (out_ready) m_mode <= 0;
        default: m_mode <= 0;
      endcase
    end
  end

  // Cycle-by-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready16", ir16, m_mode == 1);
      chk("m_in_ready32", ir32, m_mode == 1);
      chk("m_out_valid16", ov16, m_mode == 2);
      chk("m_out_valid32", ov32, m_mode == 2);
      chk("m_busy16", bz16, m_mode != 0);
      chk("m_busy32", bz32, m_mode != 0);
      if (m_mode == 2) begin
        chk("m_out_data16", $signed(od16), m_d16);
        chk("m_out_sat16", os16, m_s16);
        chk("m_out_data32", $signed(od32), m_d32);
        chk("m_out_sat32", os32, m_s32);
      end
    end
  end

  // One complete run: start, feed vq (gaps from vpat or random), then hold/handshake.
  task automatic run_t(input int n, input bit lit, input longint e16, input bit es16,
                       input longint e32, input bit es32, input int hold,
                       input bit rgap, input bit poke_start);
    int  idx = 0;
    int  guard = 0;
    bit  acc;
    @(posedge clk); #1; start = 1'b1; len = n[15:0];
    @(posedge clk); #1; start = 1'b0; len = 16'($urandom);
    while (idx < n && guard < 4 * n + 100) begin
      if (vpat.size() > 0) in_valid = vpat.pop_front();
      else if (rgap) in_valid = 1'($urandom_range(0, 1));
      else in_valid = 1'b1;
      in_data = vq[idx];
      @(negedge clk); acc = in_valid && ir16;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    if (idx < n) chk("beat_timeout", idx, n);
    in_valid = 1'b0; in_data = $urandom; out_ready = 1'b0;
    @(negedge clk);
    if (lit) begin
      chk("latency_valid", ov16, 1);
      chk("in_ready_drop", ir16, 0);
      chk("lit_data16", $signed(od16), e16);
      chk("lit_sat16", os16, es16);
      chk("lit_data32", $signed(od32), e32);
      chk("lit_sat32", os32, es32);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      start = poke_start && (k == 1);
      len = 16'd5;
      @(negedge clk);
      if (lit) begin
        chk("hold_valid", ov16, 1);
        chk("hold_data16", $signed(od16), e16);
      end
    end
    @(posedge clk); #1; start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    if (lit) begin
      chk("post_hs_busy", bz16, 0);
      chk("post_hs_valid", ov32, 0);
    end
    vq.delete();
    vpat.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 16'd0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", ir16, 0); chk("rst_out_valid", ov32, 0);
    chk("rst_out_data", od16, 0); chk("rst_sat", os32, 0); chk("rst_busy", bz16, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    vq = '{10, -3, 7, 100};
    run_t(4, 1'b1, 114, 1'b0, 114, 1'b0, 0, 1'b0, 1'b0);
    vq = '{30000, 30000};
    run_t(2, 1'b1, 32767, 1'b1, 60000, 1'b0, 0, 1'b0, 1'b0);
    vq = '{-20000, -20000, -20000};
    run_t(3, 1'b1, -32768, 1'b1, -60000, 1'b0, 0, 1'b0, 1'b0);
    vq = '{-5};
    run_t(1, 1'b1, -5, 1'b0, -5, 1'b0, 5, 1'b0, 1'b1);
    vq = '{1, 2, 3};
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_t(3, 1'b1, 6, 1'b0, 6, 1'b0, 0, 1'b0, 1'b0);
    run_t(0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Reset in the middle of a run discards the partial sum.
    @(posedge clk); #1; start = 1'b1; len = 16'd4;
    @(posedge clk); #1; start = 1'b0; in_valid = 1'b1; in_data = 32'd1000;
    repeat (2) @(posedge clk);
    #1; in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", ov16, 0); chk("midrst_ready", ir16, 0);
    chk("midrst_busy", bz32, 0); chk("midrst_data", od16, 0); chk("midrst_sat", os16, 0);
    vq = '{7};
    run_t(1, 1'b1, 7, 1'b0, 7, 1'b0, 0, 1'b0, 1'b0);

    // Randomized runs checked by the model only.
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++)
        vq.push_back(($urandom_range(0, 1) == 1) ? int'($urandom) : $urandom_range(0, 40000) - 20000);
      run_t(n, 1'b0, 0, 1'b0, 0, 1'b0, $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
    end

    // Longest run of the largest positive term: exact sum far beyond 32 bits.
    for (int i = 0; i < 65535; i++) vq.push_back(32'h7FFF_FFFF);
    run_t(65535, 1'b1, 32767, 1'b1, 64'sh7FFF_FFFF, 1'b1, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
